// File: rtl/dmem_lsu.sv
// ============================================================================
// Module   : dmem_lsu
// Brief    : Load/store unit driving a word-addressed, async-read data memory;
//            sub-word stores are done as read-modify-write.
// Revision : 1.0
// ============================================================================
`default_nettype none

module dmem_lsu #(
  parameter int DEPTH = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_funct3,
  input  logic        req_store,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic        mem_we,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic [30:0] c_depth = 31'(DEPTH);

  state_t      r_state;
  state_t      w_next;
  logic [2:0]  r_funct3;
  logic        r_store;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic        r_err;

  logic        w_accept;
  logic        w_req_err;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load;
  logic [31:0] w_merge;

  assign w_accept = req_valid & req_ready;

  always_comb begin
    w_req_err = 1'b0;
    case (req_funct3)
      3'b000, 3'b100: w_req_err = 1'b0;
      3'b001, 3'b101: w_req_err = req_addr[0];
      3'b010:         w_req_err = (req_addr[1:0] != 2'b00);
      default:        w_req_err = 1'b1;
    endcase
    // Unsigned variants have no store form.
    if (req_store && req_funct3[2])
      w_req_err = 1'b1;
    if ({1'b0, req_addr[31:2]} >= c_depth)
      w_req_err = 1'b1;
  end

  always_comb begin
    w_byte = mem_rdata[7:0];
    case (r_addr[1:0])
      2'd0: w_byte = mem_rdata[7:0];
      2'd1: w_byte = mem_rdata[15:8];
      2'd2: w_byte = mem_rdata[23:16];
      2'd3: w_byte = mem_rdata[31:24];
      default: w_byte = mem_rdata[7:0];
    endcase
    w_half = r_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (r_funct3)
      3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
      3'b100:  w_load = {24'd0, w_byte};
      3'b001:  w_load = {{16{w_half[15]}}, w_half};
      3'b101:  w_load = {16'd0, w_half};
      default: w_load = mem_rdata;
    endcase
  end

  always_comb begin
    w_merge = mem_rdata;
    if (r_funct3[1:0] == 2'b00) begin
      case (r_addr[1:0])
        2'd0: w_merge[7:0]   = r_wdata[7:0];
        2'd1: w_merge[15:8]  = r_wdata[7:0];
        2'd2: w_merge[23:16] = r_wdata[7:0];
        2'd3: w_merge[31:24] = r_wdata[7:0];
        default: w_merge = mem_rdata;
      endcase
    end else if (r_addr[1]) begin
      w_merge[31:16] = r_wdata[15:0];
    end else begin
      w_merge[15:0] = r_wdata[15:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    mem_we     = 1'b0;
    mem_wdata  = 32'd0;
    case (r_state)
      IDLE: begin
        req_ready = ~rst;
        if (w_accept) begin
          if (w_req_err)                             w_next = RESP;
          else if (req_store && req_funct3 == 3'b010) w_next = WRITE;
          else                                       w_next = READ;
        end
      end
      READ:  w_next = r_store ? WRITE : RESP;
      WRITE: begin
        mem_we    = 1'b1;
        mem_wdata = r_wdata;
        w_next    = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  assign mem_addr   = {2'b00, r_addr[31:2]};
  assign resp_rdata = r_rdata;
  assign resp_err   = r_err;

  // r_wdata is overwritten with the merged word so WRITE drives one register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_funct3 <= 3'd0;
      r_store  <= 1'b0;
      r_addr   <= 32'd0;
      r_wdata  <= 32'd0;
      r_rdata  <= 32'd0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (w_accept) begin
          r_funct3 <= req_funct3;
          r_store  <= req_store;
          r_addr   <= req_addr;
          r_wdata  <= req_wdata;
          r_rdata  <= 32'd0;
          r_err    <= w_req_err;
        end
        READ: begin
          if (r_store) r_wdata <= w_merge;
          else         r_rdata <= w_load;
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dmem_lsu.sv
// ============================================================================
// Module   : tb_dmem_lsu
// Brief    : Directed self-checking bench for dmem_lsu with a behavioural memory.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_dmem_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_funct3;
  logic        req_store;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [31:0] mem [0:1023];
  int          we_cnt;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  int          lat;
  int          errors = 0;
  int          checks = 0;

  dmem_lsu #(.DEPTH(1024)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_funct3(req_funct3),
    .req_store(req_store), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[9:0]];

  always @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr[9:0]] <= mem_wdata;
      wr_addr <= mem_addr;
      wr_data <= mem_wdata;
      we_cnt  <= we_cnt + 1;
    end
  end

  // Present one request, then wait (bounded) for resp_valid; lat counts
  // cycles from the accept edge to the first response cycle.
  task automatic send(input logic st, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    we_cnt     = 0;
    req_valid  = 1'b1;
    req_store  = st;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = d;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic ack();
    @(negedge clk);
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #12;
    checks++;
    if ({req_ready, resp_valid, resp_err, mem_we} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ctl: got rdy/vld/err/we=%b expected 0000",
               {req_ready, resp_valid, resp_err, mem_we});
    end
    checks++;
    if ({resp_rdata, mem_addr, mem_wdata} !== 96'd0) begin
      errors++;
      $display("FAIL reset_data: rdata=%h addr=%h wdata=%h expected all 0",
               resp_rdata, mem_addr, mem_wdata);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: got %b expected 1", req_ready);
    end
  endtask

  task automatic test_reset_mid_write();
    mem[4] = 32'h0000_0055;
    @(negedge clk);
    we_cnt     = 0;
    req_valid  = 1'b1;
    req_store  = 1'b1;
    req_funct3 = 3'b010;
    req_addr   = 32'h10;
    req_wdata  = 32'h1234_5678;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    checks++;
    if (mem_we !== 1'b1) begin
      errors++;
      $display("FAIL midwrite_we_before: got %b expected 1", mem_we);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({mem_we, resp_valid, req_ready} !== 3'b000) begin
      errors++;
      $display("FAIL midwrite_abort: got we/vld/rdy=%b expected 000",
               {mem_we, resp_valid, req_ready});
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (mem[4] !== 32'h0000_0055 || we_cnt !== 0) begin
      errors++;
      $display("FAIL midwrite_mem: word4=%h writes=%0d expected 00000055 and 0",
               mem[4], we_cnt);
    end
    checks++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL midwrite_idle: vld=%b rdy=%b expected 0 1", resp_valid, req_ready);
    end
  endtask

  task automatic test_sw_lw();
    send(1'b1, 3'b010, 32'h20, 32'hDEAD_BEEF);
    checks++;
    if (lat !== 2 || resp_err !== 1'b0 || resp_rdata !== 32'd0) begin
      errors++;
      $display("FAIL sw_resp: lat=%0d err=%b rdata=%h expected 2 0 00000000",
               lat, resp_err, resp_rdata);
    end
    checks++;
    if (we_cnt !== 1 || wr_addr !== 32'd8 || wr_data !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL sw_write: writes=%0d addr=%h data=%h expected 1 8 deadbeef",
               we_cnt, wr_addr, wr_data);
    end
    ack();
    send(1'b0, 3'b010, 32'h20, 32'd0);
    checks++;
    if (lat !== 2 || resp_rdata !== 32'hDEAD_BEEF || resp_err !== 1'b0 || we_cnt !== 0) begin
      errors++;
      $display("FAIL lw_after_sw: lat=%0d rdata=%h err=%b writes=%0d expected 2 deadbeef 0 0",
               lat, resp_rdata, resp_err, we_cnt);
    end
    ack();
  endtask

  task automatic test_subword_store();
    mem[8] = 32'h1122_3344;
    send(1'b1, 3'b000, 32'h21, 32'h0000_00AB);
    checks++;
    if (lat !== 3 || resp_err !== 1'b0) begin
      errors++;
      $display("FAIL sb_resp: lat=%0d err=%b expected 3 0", lat, resp_err);
    end
    checks++;
    if (we_cnt !== 1 || wr_addr !== 32'd8 || wr_data !== 32'h1122_AB44) begin
      errors++;
      $display("FAIL sb_merge: writes=%0d addr=%h data=%h expected 1 8 1122ab44",
               we_cnt, wr_addr, wr_data);
    end
    ack();
    send(1'b1, 3'b001, 32'h22, 32'hFFFF_5A6B);
    checks++;
    if (lat !== 3 || wr_data !== 32'h5A6B_AB44 || mem[8] !== 32'h5A6B_AB44) begin
      errors++;
      $display("FAIL sh_merge: lat=%0d data=%h word=%h expected 3 5a6bab44 5a6bab44",
               lat, wr_data, mem[8]);
    end
    ack();
  endtask

  task automatic test_load_extend();
    logic [2:0]  f3  [4] = '{3'b000, 3'b100, 3'b001, 3'b101};
    logic [31:0] ad  [4] = '{32'h20, 32'h20, 32'h22, 32'h22};
    logic [31:0] exp [4] = '{32'hFFFF_FF85, 32'h0000_0085, 32'hFFFF_80F0, 32'h0000_80F0};
    mem[8] = 32'h80F0_7F85;
    for (int i = 0; i < 4; i++) begin
      send(1'b0, f3[i], ad[i], 32'd0);
      checks++;
      if (lat !== 2 || resp_rdata !== exp[i] || resp_err !== 1'b0) begin
        errors++;
        $display("FAIL load_ext[%0d]: lat=%0d rdata=%h err=%b expected 2 %h 0",
                 i, lat, resp_rdata, resp_err, exp[i]);
      end
      ack();
    end
    send(1'b0, 3'b100, 32'h23, 32'd0);
    checks++;
    if (resp_rdata !== 32'h0000_0080) begin
      errors++;
      $display("FAIL lbu_byte3: got %h expected 00000080", resp_rdata);
    end
    ack();
  endtask

  task automatic test_errors();
    logic        st [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [2:0]  f3 [5] = '{3'b010, 3'b001, 3'b010, 3'b011, 3'b100};
    logic [31:0] ad [5] = '{32'h22, 32'h21, 32'h1000, 32'h20, 32'h20};
    for (int i = 0; i < 5; i++) begin
      send(st[i], f3[i], ad[i], 32'hFFFF_FFFF);
      checks++;
      if (lat !== 1 || resp_err !== 1'b1 || resp_rdata !== 32'd0 || we_cnt !== 0) begin
        errors++;
        $display("FAIL err_case[%0d]: lat=%0d err=%b rdata=%h writes=%0d expected 1 1 0 0",
                 i, lat, resp_err, resp_rdata, we_cnt);
      end
      ack();
    end
    send(1'b0, 3'b010, 32'hFFC, 32'd0);
    checks++;
    if (lat !== 2 || resp_err !== 1'b0) begin
      errors++;
      $display("FAIL last_word_ok: lat=%0d err=%b expected 2 0", lat, resp_err);
    end
    ack();
  endtask

  task automatic test_back_to_back();
    logic ok;
    mem[8] = 32'hCAFE_F00D;
    mem[9] = 32'h0BAD_CAFE;
    send(1'b0, 3'b010, 32'h20, 32'd0);
    @(negedge clk);
    req_valid  = 1'b1;
    req_store  = 1'b0;
    req_funct3 = 3'b010;
    req_addr   = 32'h24;
    ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      if (resp_valid !== 1'b1 || resp_rdata !== 32'hCAFE_F00D ||
          resp_err !== 1'b0 || req_ready !== 1'b0) ok = 1'b0;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL stall_stable: vld=%b rdata=%h err=%b rdy=%b expected 1 cafef00d 0 0",
               resp_valid, resp_rdata, resp_err, req_ready);
    end
    @(negedge clk);
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    checks++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL stall_release: vld=%b rdy=%b expected 0 1", resp_valid, req_ready);
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    checks++;
    if (req_ready !== 1'b0) begin
      errors++;
      $display("FAIL next_accept: rdy=%b expected 0", req_ready);
    end
    lat = 1;
    while (!resp_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checks++;
    if (lat !== 2 || resp_rdata !== 32'h0BAD_CAFE) begin
      errors++;
      $display("FAIL next_resp: lat=%0d rdata=%h expected 2 0badcafe", lat, resp_rdata);
    end
    ack();
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
    we_cnt     = 0;
    wr_addr    = 32'd0;
    wr_data    = 32'd0;
    req_valid  = 1'b0;
    req_store  = 1'b0;
    req_funct3 = 3'b000;
    req_addr   = 32'd0;
    req_wdata  = 32'd0;
    resp_ready = 1'b0;
    test_reset();
    test_reset_mid_write();
    test_sw_lw();
    test_subword_store();
    test_load_extend();
    test_errors();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
